// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared definitions for the SLC-3 memory bus. Used by the
//                memory responder and by the CPU control unit that has to
//                agree with it on the timing of the ready strobe R.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_bus_pkg;

    // Width of the wait-state counter; bounds WAIT_STATES to 0..c_WAIT_MAX.
    localparam int c_WAIT_CNT_W = 4;
    localparam int c_WAIT_MAX   = (1 << c_WAIT_CNT_W) - 1;

    // Default location of the memory-mapped switch/hex I/O word.
    localparam logic [15:0] c_MMIO_ADDR_DEFAULT = 16'hFFFF;

    // Responder bus states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_ram_16.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ram_16
//  Description : Single-port 16-bit word RAM, 2**ADDR_W deep. Synchronous
//                write, registered read (read-before-write), no reset so it
//                maps onto block RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_ram_16 #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    output logic [15:0]       o_rdata
);

    logic [15:0] r_mem [0:(1 << ADDR_W) - 1];

    // Write when enabled; the read port registers the addressed word every cycle.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Target side of the SLC-3 memory bus. Captures a request on
//                MEM_EN, waits WAIT_STATES cycles, then performs the access
//                on the captured address/data and pulses R. Decodes one
//                memory-mapped I/O word (SW in, HEX_Data out) ahead of the
//                on-chip RAM; anything else is flagged with ADDR_ERR.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] MMIO_ADDR   = c_MMIO_ADDR_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MEM_EN,
    input  logic        MEM_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] SW,
    output logic [15:0] MDR_Data,
    output logic        R,
    output logic        ADDR_ERR,
    output logic [15:0] HEX_Data
);

    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LOAD = c_WAIT_CNT_W'(WAIT_STATES);

    // Illegal configurations stop elaboration.
    generate
        if (WAIT_STATES < 0 || WAIT_STATES > c_WAIT_MAX) begin : g_bad_wait_states
            $error("mem_responder: WAIT_STATES must lie in 0..%0d", c_WAIT_MAX);
        end
        if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr_w
            $error("mem_responder: ADDR_W must lie in 1..16");
        end
    endgenerate

    mem_state_t              r_state;
    logic [c_WAIT_CNT_W-1:0] r_cnt;
    logic [15:0]             r_addr;
    logic [15:0]             r_wdata;
    logic                    r_we;
    logic [15:0]             r_sw;

    logic                    w_is_mmio;
    logic                    w_in_ram;
    logic                    w_ram_we;
    logic [ADDR_W-1:0]       w_ram_addr;
    logic [15:0]             w_ram_rdata;

    // Decode of the captured address: the I/O word wins over RAM.
    assign w_is_mmio = (r_addr == MMIO_ADDR);
    assign w_in_ram  = ((32'(r_addr) >> ADDR_W) == 32'd0);

    // The RAM is written only on the response cycle of a RAM write.
    assign w_ram_we  = (r_state == RESP) && r_we && !w_is_mmio && w_in_ram;

    // In IDLE the RAM looks at MAR so the registered read data is already
    // valid for the captured address when WAIT_STATES is 0; afterwards it
    // follows the captured address so bus changes cannot disturb the access.
    assign w_ram_addr = (r_state == IDLE) ? MAR[ADDR_W-1:0] : r_addr[ADDR_W-1:0];

    sync_ram_16 #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (CLK),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Bus FSM: capture, wait-state count, access/response and hold-off until
    // the CPU drops MEM_EN; R, ADDR_ERR, MDR_Data and HEX_Data are registered.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_sw     <= '0;
            R        <= 1'b0;
            ADDR_ERR <= 1'b0;
            MDR_Data <= '0;
            HEX_Data <= '0;
        end else begin
            R        <= 1'b0;
            ADDR_ERR <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (MEM_EN) begin
                        r_addr  <= MAR;
                        r_wdata <= MDR;
                        r_we    <= MEM_WE;
                        r_cnt   <= c_WAIT_LOAD;
                        if (WAIT_STATES == 0) begin
                            r_sw    <= SW;
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!MEM_EN) begin
                        // CPU withdrew the request: nothing is performed.
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == c_WAIT_CNT_W'(1)) begin
                            r_sw    <= SW;
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    R       <= 1'b1;
                    r_state <= HOLD;
                    if (w_is_mmio) begin
                        if (r_we) begin
                            HEX_Data <= r_wdata;
                        end else begin
                            MDR_Data <= r_sw;
                        end
                    end else if (w_in_ram) begin
                        if (!r_we) begin
                            MDR_Data <= w_ram_rdata;
                        end
                    end else begin
                        ADDR_ERR <= 1'b1;
                        if (!r_we) begin
                            MDR_Data <= 16'h0000;
                        end
                    end
                end
                HOLD: begin
                    // Refuse a new request until MEM_EN has been seen low.
                    if (!MEM_EN) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Bench for mem_responder. Two instances (WAIT_STATES 2 and 0)
//                share one bus; a transaction-level model predicts, for each
//                instance, the cycle of R and the resulting output values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    typedef struct {
        int          inst;
        int          cyc;
        bit          err;
        bit          upd_mdr;
        logic [15:0] mdr;
        bit          upd_hex;
        logic [15:0] hex;
    } ev_t;

    logic        CLK    = 1'b0;
    logic        Reset  = 1'b1;
    logic        MEM_EN = 1'b0;
    logic        MEM_WE = 1'b0;
    logic [15:0] MAR    = '0;
    logic [15:0] MDR    = '0;
    logic [15:0] SW     = '0;

    logic        r_a, r_b, err_a, err_b;
    logic [15:0] mdr_a, mdr_b, hex_a, hex_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] mem [2][1024];
    bit          e_r   [2];
    bit          e_err [2];
    logic [15:0] e_mdr [2];
    logic [15:0] e_hex [2];
    ev_t         evq [$];
    logic [15:0] pool [16];

    mem_responder #(.ADDR_W(10), .WAIT_STATES(2), .MMIO_ADDR(16'hFFFF)) u_dut_ws2 (
        .CLK(CLK), .Reset(Reset), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MAR(MAR), .MDR(MDR),
        .SW(SW), .MDR_Data(mdr_a), .R(r_a), .ADDR_ERR(err_a), .HEX_Data(hex_a));

    mem_responder #(.ADDR_W(10), .WAIT_STATES(0), .MMIO_ADDR(16'hFFFF)) u_dut_ws0 (
        .CLK(CLK), .Reset(Reset), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MAR(MAR), .MDR(MDR),
        .SW(SW), .MDR_Data(mdr_b), .R(r_b), .ADDR_ERR(err_b), .HEX_Data(hex_b));

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int ws_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input int inst, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%h expected=%h", name, inst, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_lit(input string name, input logic [15:0] ea, input logic [15:0] eb);
        chk(name, 0, mdr_a, ea);
        chk(name, 1, mdr_b, eb);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_R"}, 0, {15'd0, r_a}, 16'd0);
        chk({name, "_R"}, 1, {15'd0, r_b}, 16'd0);
        chk({name, "_ERR"}, 0, {15'd0, err_a}, 16'd0);
        chk({name, "_ERR"}, 1, {15'd0, err_b}, 16'd0);
        chk({name, "_MDR"}, 0, mdr_a, 16'd0);
        chk({name, "_MDR"}, 1, mdr_b, 16'd0);
        chk({name, "_HEX"}, 0, hex_a, 16'd0);
        chk({name, "_HEX"}, 1, hex_b, 16'd0);
    endtask

    // One bus transaction. d: MEM_EN is first seen low at capture edge + d.
    // rr != 0: Reset is asserted just after capture edge + rr for one cycle.
    task automatic run_req(input bit we, input logic [15:0] addr, input logic [15:0] data,
                           input logic [15:0] sw, input int d_in, input int rr);
        int  cap, d, endc, w;
        bit  done;
        ev_t ev;
        d      = (rr != 0) ? rr + 1 : d_in;
        SW     = sw;
        MEM_EN = 1'b1;
        MEM_WE = we;
        MAR    = addr;
        MDR    = data;
        cap    = cyc + 1;
        endc   = cap + d;
        for (int i = 0; i < 2; i++) begin
            w    = ws_of(i);
            done = (w == 0 || d > w) && (rr == 0 || w + 1 <= rr);
            if (done) begin
                ev.inst = i; ev.cyc = cap + w + 1; ev.err = 1'b0;
                ev.upd_mdr = 1'b0; ev.mdr = '0; ev.upd_hex = 1'b0; ev.hex = '0;
                if (addr == 16'hFFFF) begin
                    if (we) begin ev.upd_hex = 1'b1; ev.hex = data; end
                    else    begin ev.upd_mdr = 1'b1; ev.mdr = sw;   end
                end else if (addr < 16'd1024) begin
                    if (we) mem[i][addr[9:0]] = data;
                    else begin ev.upd_mdr = 1'b1; ev.mdr = mem[i][addr[9:0]]; end
                end else begin
                    ev.err = 1'b1;
                    if (!we) begin ev.upd_mdr = 1'b1; ev.mdr = 16'h0000; end
                end
                evq.push_back(ev);
                if (cap + w + 2 > endc) endc = cap + w + 2;
            end
        end
        if (rr != 0 && cap + rr + 1 > endc) endc = cap + rr + 1;
        while (cyc < endc) begin
            tick();
            if (cyc == cap + d - 1) MEM_EN = 1'b0;
            if (rr != 0 && cyc == cap + rr) begin
                Reset = 1'b1;
                #1;
                chk_zero("reset_mid");
            end
            if (rr != 0 && cyc == cap + rr + 1) Reset = 1'b0;
            // Bus values after capture must not influence the access.
            MAR    = 16'($urandom);
            MDR    = 16'($urandom);
            MEM_WE = 1'($urandom);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        logic       ar, ae;
        logic [15:0] am, ah;
        for (int i = 0; i < 2; i++) begin
            e_r[i] = 1'b0; e_err[i] = 1'b0; e_mdr[i] = '0; e_hex[i] = '0;
        end
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                if (Reset) begin
                    e_r[i] = 1'b0; e_err[i] = 1'b0; e_mdr[i] = '0; e_hex[i] = '0;
                end else begin
                    e_r[i]   = 1'b0;
                    e_err[i] = 1'b0;
                    for (int k = 0; k < evq.size(); k++) begin
                        if (evq[k].inst == i && evq[k].cyc == cyc) begin
                            e_r[i]   = 1'b1;
                            e_err[i] = evq[k].err;
                            if (evq[k].upd_mdr) e_mdr[i] = evq[k].mdr;
                            if (evq[k].upd_hex) e_hex[i] = evq[k].hex;
                            evq.delete(k);
                            break;
                        end
                    end
                end
                if (i == 0) begin ar = r_a; ae = err_a; am = mdr_a; ah = hex_a; end
                else        begin ar = r_b; ae = err_b; am = mdr_b; ah = hex_b; end
                chk("R", i, {15'd0, ar}, {15'd0, e_r[i]});
                chk("ADDR_ERR", i, {15'd0, ae}, {15'd0, e_err[i]});
                chk("MDR_Data", i, am, e_mdr[i]);
                chk("HEX_Data", i, ah, e_hex[i]);
            end
            if (Reset) evq.delete();
        end
    end

    // Stimulus: reset, directed scenarios, then randomized traffic.
    initial begin
        bit          we;
        int          sel, d, rr;
        logic [15:0] addr;

        Reset = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        Reset = 1'b0;
        tick();

        pool[0] = 16'h0005; pool[1] = 16'h0010; pool[2] = 16'h0020; pool[3] = 16'h0000;
        pool[4] = 16'h03FF; pool[5] = 16'h0400; pool[6] = 16'hFFFF; pool[7] = 16'hFFFE;
        pool[8] = 16'h8000;
        for (int k = 9; k < 16; k++) pool[k] = 16'($urandom_range(0, 1023));
        for (int k = 0; k < 16; k++)
            if (pool[k] < 16'd1024) run_req(1'b1, pool[k], 16'($urandom), 16'h0, 4, 0);

        // Write then read back through RAM.
        run_req(1'b1, 16'h0005, 16'h1234, 16'h0, 4, 0);
        run_req(1'b0, 16'h0005, 16'h0000, 16'h0, 4, 0);
        chk_all_lit("rd_0005", 16'h1234, 16'h1234);

        // I/O word: switches in, hex out, RAM untouched.
        run_req(1'b0, 16'hFFFF, 16'h0000, 16'hBEEF, 4, 0);
        chk_all_lit("rd_sw", 16'hBEEF, 16'hBEEF);
        run_req(1'b1, 16'hFFFF, 16'hA5A5, 16'h0, 4, 0);
        chk("wr_hex", 0, hex_a, 16'hA5A5);
        chk("wr_hex", 1, hex_b, 16'hA5A5);
        run_req(1'b0, 16'h0005, 16'h0000, 16'h0, 4, 0);
        chk_all_lit("ram_after_hex", 16'h1234, 16'h1234);

        // Out-of-range address.
        run_req(1'b1, 16'h0400, 16'h7777, 16'h0, 4, 0);
        run_req(1'b0, 16'h0400, 16'h0000, 16'h0, 4, 0);
        chk_all_lit("rd_0400", 16'h0000, 16'h0000);

        // Abort during WAIT (the zero-wait instance completes before the drop).
        run_req(1'b1, 16'h0010, 16'h0AAA, 16'h0, 4, 0);
        run_req(1'b1, 16'h0010, 16'h1111, 16'h0, 2, 0);
        run_req(1'b0, 16'h0010, 16'h0000, 16'h0, 4, 0);
        chk_all_lit("abort_rd", 16'h0AAA, 16'h1111);

        // MEM_EN held long after R; MEM_EN dropped during RESP.
        run_req(1'b0, 16'h0005, 16'h0000, 16'h0, 14, 0);
        chk_all_lit("hold_rd", 16'h1234, 16'h1234);
        run_req(1'b0, 16'h0010, 16'h0000, 16'h0, 3, 0);

        // Reset during WAIT of a write.
        run_req(1'b1, 16'h0020, 16'h0BBB, 16'h0, 4, 0);
        run_req(1'b1, 16'h0020, 16'h2222, 16'h0, 4, 1);
        run_req(1'b0, 16'h0020, 16'h0000, 16'h0, 4, 0);
        chk_all_lit("rst_rd", 16'h0BBB, 16'h2222);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            we  = 1'($urandom);
            sel = $urandom_range(0, 7);
            if (sel <= 4)      addr = pool[$urandom_range(0, 15)];
            else if (sel == 5) addr = 16'hFFFF;
            else if (sel == 6) addr = 16'($urandom_range(16'h0400, 16'hFFFE));
            else               addr = we ? 16'($urandom) : pool[$urandom_range(0, 15)];
            d  = $urandom_range(1, 6);
            rr = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
            run_req(we, addr, 16'($urandom), 16'($urandom), d, rr);
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
